// File: rtl/control_host.sv
`timescale 1ns/1ps
// control_host
// -----------------------------------------------------------------------------
// Host-side SPI master (mode 0, MSB first) for the coax interface control
// protocol. One request is accepted at a time over a valid/ready handshake. It
// is framed as a single chip-select transaction of 1-3 bytes. Reply bytes are
// captured from MISO and returned as a one-cycle response pulse.
//
// Parameters
//   CLK_DIV     SCLK half-period in clk cycles (>= 1)
//   GAP_CYCLES  length of CS setup, inter-byte gap, CS hold and deselect (>= 1)
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   req_valid_i     request present
//   req_ready_o     high only while idle; accept on req_valid_i & req_ready_o
//   req_op_i        0 READ_REG, 1 WRITE_REG, 2 TX, 3 RX, 4 RESET, 5-7 illegal
//   req_reg_i       register select (high nibble of the command byte)
//   req_mask_i      WRITE_REG mask
//   req_data_i      WRITE_REG value in [7:0], TX word in [9:0]
//   rsp_valid_o     one-cycle completion pulse
//   rsp_data_o      response word, held until the next rsp_valid_o
//   rsp_error_o     error flag, qualified by rsp_valid_o
//   busy_o          high from accept until the end of deselect
//   spi_cs_n_o      chip select, active low
//   spi_sclk_o      serial clock, idles low
//   spi_mosi_o      master out
//   spi_miso_i      master in, sampled when SCLK rises
// -----------------------------------------------------------------------------
module control_host #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [3:0]  req_reg_i,
    input  logic [7:0]  req_mask_i,
    input  logic [9:0]  req_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_error_o,
    output logic        busy_o,
    output logic        spi_cs_n_o,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    localparam logic [2:0] OP_READ_REG  = 3'd0;
    localparam logic [2:0] OP_WRITE_REG = 3'd1;
    localparam logic [2:0] OP_TX        = 3'd2;
    localparam logic [2:0] OP_RX        = 3'd3;
    localparam logic [2:0] OP_RESET     = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_CS_HOLD,
        ST_DESEL
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [3:0]         reg_q, reg_d;
    logic [7:0]         mask_q, mask_d;
    logic [9:0]         data_q, data_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [7:0]         tx_sh_q, tx_sh_d;
    logic [15:0]        rx_sh_q, rx_sh_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic               rsp_error_q, rsp_error_d;

    logic [7:0]         cur_byte;
    logic [1:0]         last_idx;
    logic [15:0]        rsp_value;
    logic               rsp_err_value;

    // Byte to transmit for the latched op at the current byte index, and the
    // index of the final byte of the frame.
    always_comb begin
        cur_byte = 8'h00;
        last_idx = 2'd0;
        case (op_q)
            OP_READ_REG: begin
                last_idx = 2'd1;
                if (byte_idx_q == 2'd0) cur_byte = {reg_q, 4'h2};
            end
            OP_WRITE_REG: begin
                last_idx = 2'd2;
                case (byte_idx_q)
                    2'd0:    cur_byte = {reg_q, 4'h3};
                    2'd1:    cur_byte = mask_q;
                    default: cur_byte = data_q[7:0];
                endcase
            end
            OP_TX: begin
                last_idx = 2'd2;
                case (byte_idx_q)
                    2'd0:    cur_byte = 8'h04;
                    2'd1:    cur_byte = {6'b0, data_q[9:8]};
                    default: cur_byte = data_q[7:0];
                endcase
            end
            OP_RX: begin
                last_idx = 2'd2;
                if (byte_idx_q == 2'd0) cur_byte = 8'h05;
            end
            OP_RESET: begin
                last_idx = 2'd0;
                cur_byte = 8'h0f;
            end
            default: begin
                last_idx = 2'd0;
                cur_byte = 8'h00;
            end
        endcase
    end

    // The receive shifter keeps only the last 16 bits, so MISO byte 1 falls
    // out naturally on 3-byte frames and sits unused in [15:8] on 2-byte reads.
    always_comb begin
        rsp_value     = 16'h0000;
        rsp_err_value = 1'b0;
        case (op_q)
            OP_READ_REG: rsp_value = {8'h00, rx_sh_q[7:0]};
            OP_TX: begin
                rsp_value     = {8'h00, rx_sh_q[7:0]};
                rsp_err_value = (rx_sh_q[7:0] != 8'h00);
            end
            OP_RX: begin
                rsp_value     = rx_sh_q;
                rsp_err_value = rx_sh_q[15];
            end
            default: begin
                rsp_value     = 16'h0000;
                rsp_err_value = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            reg_q       <= 4'd0;
            mask_q      <= 8'd0;
            data_q      <= 10'd0;
            byte_idx_q  <= 2'd0;
            bit_cnt_q   <= 3'd0;
            div_q       <= '0;
            gap_q       <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            tx_sh_q     <= 8'd0;
            rx_sh_q     <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            reg_q       <= reg_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            byte_idx_q  <= byte_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        reg_d       = reg_q;
        mask_d      = mask_q;
        data_d      = data_q;
        byte_idx_d  = byte_idx_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        gap_d       = gap_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                byte_idx_d = 2'd0;
                bit_cnt_d  = 3'd0;
                div_d      = '0;
                gap_d      = '0;
                sclk_d     = 1'b0;
                mosi_d     = 1'b0;
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    reg_d   = req_reg_i;
                    mask_d  = req_mask_i;
                    data_d  = req_data_i;
                    rx_sh_d = 16'h0000;
                    if (req_op_i <= OP_RESET) begin
                        state_d = ST_CS_SETUP;
                    end else begin
                        // Illegal ops never touch the link; answer at once
                        // and stay ready.
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 16'h0000;
                        rsp_error_d = 1'b1;
                    end
                end
            end

            ST_CS_SETUP, ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_SHIFT;
                    // First bit goes out at the start of the first low half.
                    mosi_d  = cur_byte[7];
                    tx_sh_d = {cur_byte[6:0], 1'b0};
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_SHIFT: begin
                // Sample in the first cycle SCLK is seen high.
                if (sclk_q && (div_q == '0)) begin
                    rx_sh_d = {rx_sh_q[14:0], spi_miso_i};
                end
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q) begin
                        // Falling edge closes the bit.
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            mosi_d    = 1'b0;
                            if (byte_idx_q == last_idx) begin
                                state_d = ST_CS_HOLD;
                            end else begin
                                byte_idx_d = byte_idx_q + 2'd1;
                                state_d    = ST_GAP;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            mosi_d    = tx_sh_q[7];
                            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_CS_HOLD: begin
                if (gap_q == GAP_LAST) begin
                    gap_d       = '0;
                    state_d     = ST_DESEL;
                    // Response lands in the first cycle of cs_n high.
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rsp_value;
                    rsp_error_d = rsp_err_value;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            ST_DESEL: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign spi_cs_n_o  = (state_q == ST_IDLE) || (state_q == ST_DESEL);
    assign spi_sclk_o  = sclk_q;
    assign spi_mosi_o  = mosi_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_control_host.sv
`timescale 1ns/1ps
// Self-checking bench for control_host. A small SPI slave answers frames:
// register reads come from a 16-entry register file (writes update it when a
// full 3-byte frame completes), TX/RX replies come from bench-set bytes.
// Stimulus pushes hand-computed expectations into a queue; a monitor pops and
// compares on every rsp_valid pulse.
module tb_control_host;

    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 8;
    localparam int TIMEOUT    = 2000;

    localparam logic [2:0] OP_READ_REG  = 3'd0;
    localparam logic [2:0] OP_WRITE_REG = 3'd1;
    localparam logic [2:0] OP_TX        = 3'd2;
    localparam logic [2:0] OP_RX        = 3'd3;
    localparam logic [2:0] OP_RESET     = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [3:0]  req_reg;
    logic [7:0]  req_mask;
    logic [9:0]  req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_error;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;

    control_host #(
        .CLK_DIV   (CLK_DIV),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_op_i   (req_op),
        .req_reg_i  (req_reg),
        .req_mask_i (req_mask),
        .req_data_i (req_data),
        .rsp_valid_o(rsp_valid),
        .rsp_data_o (rsp_data),
        .rsp_error_o(rsp_error),
        .busy_o     (busy),
        .spi_cs_n_o (spi_cs_n),
        .spi_sclk_o (spi_sclk),
        .spi_mosi_o (spi_mosi),
        .spi_miso_i (spi_miso)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
        int          nBytes;
        int          frame;
        logic [23:0] mosi;
        int          acceptCycle;
        int          framesAt;
    } exp_t;

    exp_t sb[$];
    exp_t monExp;

    int errors = 0;
    int checks = 0;
    int cycleCnt = 0;
    int lowCnt = 0;
    int lastLow = 0;
    int framesStarted = 0;
    int rspPulses = 0;

    // slave model state
    logic [7:0] slaveRegs [16];
    logic [7:0] reply [3];
    logic [7:0] rcvd [3];
    logic [7:0] sShift = 8'h00;
    int         sByte = 0;
    int         sBit = 0;
    logic [7:0] txReply;
    logic [7:0] rxReply1;
    logic [7:0] rxReply2;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Slave: frame start resets the byte/bit position and presents reply bit 7.
    always @(negedge spi_cs_n) begin
        framesStarted++;
        sByte = 0;
        sBit = 0;
        reply[0] = 8'hff;
        reply[1] = 8'h00;
        reply[2] = 8'h00;
        rcvd[0] = 8'h00;
        rcvd[1] = 8'h00;
        rcvd[2] = 8'h00;
        spi_miso = reply[0][7];
    end

    always @(posedge spi_sclk) begin
        if (spi_cs_n === 1'b0 && sByte < 3) begin
            sShift = {sShift[6:0], spi_mosi};
            sBit++;
            if (sBit == 8) begin
                rcvd[sByte] = sShift;
                if (sByte == 0) begin
                    if (sShift[3:0] == 4'h2) begin
                        reply[1] = slaveRegs[sShift[7:4]];
                    end else if (sShift == 8'h04) begin
                        reply[2] = txReply;
                    end else if (sShift == 8'h05) begin
                        reply[1] = rxReply1;
                        reply[2] = rxReply2;
                    end
                end
                sByte++;
                sBit = 0;
            end
        end
    end

    always @(negedge spi_sclk) begin
        if (spi_cs_n === 1'b0 && sByte < 3) spi_miso = reply[sByte][7-sBit];
    end

    // A register write takes effect only if the whole frame arrived.
    always @(posedge spi_cs_n) begin
        if (sByte == 3 && rcvd[0][3:0] == 4'h3)
            slaveRegs[rcvd[0][7:4]] = (slaveRegs[rcvd[0][7:4]] & ~rcvd[1]) | (rcvd[2] & rcvd[1]);
    end

    // Monitor: counts cycles, measures the cs_n low window and checks responses.
    always @(negedge clk) begin
        cycleCnt++;
        if (spi_cs_n === 1'b0) begin
            lowCnt++;
        end else if (lowCnt != 0) begin
            lastLow = lowCnt;
            lowCnt = 0;
        end
        if (rsp_valid === 1'b1) begin
            rspPulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected rsp_valid: got data 0x%0h, expected no response", rsp_data);
            end else begin
                monExp = sb.pop_front();
                checkOutput($sformatf("txn%0d rsp_data", monExp.id), 32'(rsp_data), 32'(monExp.data));
                checkOutput($sformatf("txn%0d rsp_error", monExp.id), 32'(rsp_error), 32'(monExp.err));
                checkOutput($sformatf("txn%0d latency", monExp.id), 32'(cycleCnt - monExp.acceptCycle),
                            32'(monExp.frame + 1));
                checkOutput($sformatf("txn%0d frames", monExp.id), 32'(framesStarted - monExp.framesAt),
                            (monExp.nBytes > 0) ? 32'd1 : 32'd0);
                if (monExp.nBytes > 0) begin
                    checkOutput($sformatf("txn%0d cs_low", monExp.id), 32'(lastLow), 32'(monExp.frame));
                    checkOutput($sformatf("txn%0d nbytes", monExp.id), 32'(sByte), 32'(monExp.nBytes));
                    checkOutput($sformatf("txn%0d mosi", monExp.id), {8'h00, rcvd[0], rcvd[1], rcvd[2]},
                                {8'h00, monExp.mosi});
                end
            end
        end
    end

    task automatic applyStimulus(input int id, input logic [2:0] op, input logic [3:0] rg,
                                 input logic [7:0] mask, input logic [9:0] data,
                                 input logic [15:0] expData, input logic expErr, input int nBytes,
                                 input int frame, input logic [23:0] expMosi, output int acceptAt);
        exp_t e;
        int waited;
        @(negedge clk);
        #2;
        req_valid = 1'b1;
        req_op    = op;
        req_reg   = rg;
        req_mask  = mask;
        req_data  = data;
        waited = 0;
        while (req_ready !== 1'b1 && waited < TIMEOUT) begin
            @(negedge clk);
            #2;
            waited++;
        end
        if (waited >= TIMEOUT) begin
            checks++;
            errors++;
            $display("[TB] FAIL txn%0d accept: got no req_ready, expected ready within %0d cycles", id, TIMEOUT);
        end
        acceptAt      = cycleCnt;
        e.id          = id;
        e.data        = expData;
        e.err         = expErr;
        e.nBytes      = nBytes;
        e.frame       = frame;
        e.mosi        = expMosi;
        e.acceptCycle = cycleCnt;
        e.framesAt    = framesStarted;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs to show the request was latched at accept.
        req_valid = 1'b0;
        req_op    = 3'd7;
        req_reg   = 4'h0;
        req_mask  = 8'h00;
        req_data  = 10'h3ff;
    endtask

    task automatic waitDone();
        int n = 0;
        while ((sb.size() != 0 || req_ready !== 1'b1) && n < TIMEOUT) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++;
            errors++;
            $display("[TB] FAIL completion: got %0d responses pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a1, a2, n, pulsesBefore;
        for (int i = 0; i < 16; i++) slaveRegs[i] = 8'h00;
        slaveRegs[15] = 8'ha5;
        slaveRegs[2]  = 8'h48;
        txReply  = 8'h00;
        rxReply1 = 8'h40;
        rxReply2 = 8'h00;
        spi_miso = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_reg   = 4'h0;
        req_mask  = 8'h00;
        req_data  = 10'h000;

        repeat (3) @(negedge clk);
        checkOutput("reset cs_n", 32'(spi_cs_n), 32'd1);
        checkOutput("reset sclk", 32'(spi_sclk), 32'd0);
        checkOutput("reset mosi", 32'(spi_mosi), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset rsp_error", 32'(rsp_error), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #2;
        checkOutput("ready after reset", 32'(req_ready), 32'd1);

        $display("[TB] status read");
        applyStimulus(1, OP_READ_REG, 4'hf, 8'h00, 10'h000, 16'h00a5, 1'b0, 2, 88, 24'hf20000, a1);
        waitDone();

        $display("[TB] control register write and readback");
        applyStimulus(2, OP_WRITE_REG, 4'h2, 8'h01, 10'h001, 16'h0000, 1'b0, 3, 128, 24'h230101, a1);
        waitDone();
        applyStimulus(3, OP_READ_REG, 4'h2, 8'h00, 10'h000, 16'h0049, 1'b0, 2, 88, 24'h220000, a1);
        waitDone();

        $display("[TB] TX status");
        applyStimulus(4, OP_TX, 4'h0, 8'h00, 10'h2a5, 16'h0000, 1'b0, 3, 128, 24'h0402a5, a1);
        waitDone();
        txReply = 8'h81;
        applyStimulus(5, OP_TX, 4'h0, 8'h00, 10'h2a5, 16'h0081, 1'b1, 3, 128, 24'h0402a5, a1);
        waitDone();
        txReply = 8'h82;
        applyStimulus(6, OP_TX, 4'h9, 8'hff, 10'h155, 16'h0082, 1'b1, 3, 128, 24'h040155, a1);
        waitDone();
        txReply = 8'h00;

        $display("[TB] RX empty then error");
        applyStimulus(7, OP_RX, 4'h0, 8'h00, 10'h000, 16'h4000, 1'b0, 3, 128, 24'h050000, a1);
        waitDone();
        rxReply1 = 8'h83;
        rxReply2 = 8'h5a;
        applyStimulus(8, OP_RX, 4'h0, 8'h00, 10'h000, 16'h835a, 1'b1, 3, 128, 24'h050000, a1);
        waitDone();

        $display("[TB] illegal ops and RESET");
        applyStimulus(9, 3'd5, 4'h3, 8'h12, 10'h034, 16'h0000, 1'b1, 0, 0, 24'h000000, a1);
        waitDone();
        applyStimulus(10, OP_RESET, 4'h0, 8'h00, 10'h000, 16'h0000, 1'b0, 1, 48, 24'h0f0000, a1);
        waitDone();
        applyStimulus(11, 3'd7, 4'hf, 8'hff, 10'h3ff, 16'h0000, 1'b1, 0, 0, 24'h000000, a1);
        waitDone();

        $display("[TB] request while busy");
        applyStimulus(12, OP_READ_REG, 4'hf, 8'h00, 10'h000, 16'h00a5, 1'b0, 2, 88, 24'hf20000, a1);
        checkOutput("busy after accept", 32'(busy), 32'd1);
        checkOutput("ready after accept", 32'(req_ready), 32'd0);
        checkOutput("cs_n after accept", 32'(spi_cs_n), 32'd0);
        applyStimulus(13, OP_READ_REG, 4'h2, 8'h00, 10'h000, 16'h0049, 1'b0, 2, 88, 24'h220000, a2);
        checkOutput("accept to next ready", 32'(a2 - a1), 32'd97);
        waitDone();

        $display("[TB] reset mid-frame");
        applyStimulus(14, OP_WRITE_REG, 4'h2, 8'hff, 10'h000, 16'h0000, 1'b0, 3, 128, 24'h23ff00, a1);
        n = 0;
        while (!(sByte == 1 && sBit == 3 && spi_sclk === 1'b0) && n < TIMEOUT) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= TIMEOUT) begin
            checks++;
            errors++;
            $display("[TB] FAIL mid-frame position: got byte %0d bit %0d, expected byte 1 bit 3", sByte, sBit);
        end
        pulsesBefore = rspPulses;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        checkOutput("mid reset cs_n", 32'(spi_cs_n), 32'd1);
        checkOutput("mid reset sclk", 32'(spi_sclk), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("no rsp after reset", 32'(rspPulses - pulsesBefore), 32'd0);
        applyStimulus(15, OP_READ_REG, 4'h2, 8'h00, 10'h000, 16'h0049, 1'b0, 2, 88, 24'h220000, a1);
        waitDone();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
